odve_uart_tx: RTL and testbench

ODVE_UART_TX -- requirements
Module: odve_uart_tx

---
 rtl/odve_uart_tx.sv | 156 +++++++++++++++
 tb/tb_odve_uart_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/odve_uart_tx.sv
// odve_uart_tx: UART transmitter with a small input FIFO.
//   Frame: start(0), DATA_W data bits LSB first, optional parity, STOP_BITS stop(1).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready word handshake, in_data word to send
//   baud_div          clock cycles per bit (0 behaves as 1), latched per frame
//   tx                registered serial output, idle high
//   busy              frame in progress or words waiting
//   fifo_level        words waiting in the FIFO (not counting the one on the line)
module odve_uart_tx #(
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [DIV_W-1:0]              baud_div,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wptr, r_rptr;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic [DIV_W-1:0]  r_div, r_cnt;
  logic [3:0]        r_bitcnt;
  logic              r_tx;

  logic              w_push, w_load, w_fifo_ne, w_bit_done;
  logic              w_last_data, w_last_stop, w_tx_nxt;
  logic [DIV_W-1:0]  w_div_eff;
  logic [DATA_W-1:0] w_head;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign fifo_level  = r_wptr - r_rptr;
  assign in_ready    = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign w_fifo_ne   = (fifo_level != '0);
  // Reset blocks handshakes even though in_ready reads 1 during reset.
  assign w_push      = in_valid && in_ready && rst_n;
  assign w_head      = r_mem[r_rptr[AW-1:0]];
  assign w_div_eff   = (baud_div == '0) ? DIV_W'(1) : baud_div;
  assign w_bit_done  = (r_cnt == '0);
  assign w_last_data = (r_bitcnt == 4'(DATA_W - 1));
  assign w_last_stop = (r_bitcnt == 4'(STOP_BITS - 1));
  assign tx          = r_tx;
  assign busy        = (r_state != S_IDLE) || w_fifo_ne;

  // Next state, pop strobe and the value tx takes for the next bit period.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_tx_nxt    = r_tx;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_fifo_ne) begin
          w_state_nxt = S_START;
          w_load      = 1'b1;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: if (w_bit_done) begin
        w_state_nxt = S_DATA;
        w_tx_nxt    = r_shift[0];
      end
      S_DATA: if (w_bit_done) begin
        if (w_last_data) begin
          if (PARITY != 0) begin
            w_state_nxt = S_PAR;
            w_tx_nxt    = r_par;
          end else begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          // Shift happens on this same edge, so the next bit is at [1].
          w_tx_nxt = r_shift[1];
        end
      end
      S_PAR: if (w_bit_done) begin
        w_state_nxt = S_STOP;
        w_tx_nxt    = 1'b1;
      end
      S_STOP: if (w_bit_done && w_last_stop) begin
        // Back-to-back frames: go straight to the next start bit.
        if (w_fifo_ne) begin
          w_state_nxt = S_START;
          w_load      = 1'b1;
          w_tx_nxt    = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
          w_tx_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Storage has no reset; pointers alone define the contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_div    <= DIV_W'(1);
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_tx     <= 1'b1;
    end else begin
      r_tx <= w_tx_nxt;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_load) begin
        r_rptr  <= r_rptr + 1'b1;
        r_shift <= w_head;
        r_par   <= (PARITY == 2) ? ~(^w_head) : (^w_head);
        // Divisor is frozen for the whole frame.
        r_div   <= w_div_eff;
        r_cnt   <= w_div_eff - 1'b1;
      end else if (r_state != S_IDLE) begin
        r_cnt <= w_bit_done ? (r_div - 1'b1) : (r_cnt - 1'b1);
        if (r_state == S_DATA && w_bit_done) r_shift <= r_shift >> 1;
      end
      // Bit counter restarts on every state change, counts within DATA/STOP.
      if (w_load || (w_state_nxt != r_state)) r_bitcnt <= '0;
      else if (w_bit_done && (r_state == S_DATA || r_state == S_STOP))
        r_bitcnt <= r_bitcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_odve_uart_tx.sv
// Directed bench for odve_uart_tx. Four instances cover the parameter
// variants: u0 defaults, u1 even parity, u2 odd parity, u3 two stop bits.
module tb_odve_uart_tx;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       v;
  logic [7:0]       d [4];
  logic [15:0]      div;
  logic [3:0]       rdy, tx_w, busy_w;
  logic [2:0]       lvl [4];
  int               sel;
  logic             tx_sel, busy_sel;
  int               n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  assign tx_sel   = tx_w[sel];
  assign busy_sel = busy_w[sel];

  odve_uart_tx u0 (.clk(clk), .rst_n(rst_n), .in_valid(v[0]), .in_ready(rdy[0]), .in_data(d[0]),
                   .baud_div(div), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_level(lvl[0]));
  odve_uart_tx #(.PARITY(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(v[1]), .in_ready(rdy[1]), .in_data(d[1]),
                   .baud_div(div), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_level(lvl[1]));
  odve_uart_tx #(.PARITY(2)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(v[2]), .in_ready(rdy[2]), .in_data(d[2]),
                   .baud_div(div), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_level(lvl[2]));
  odve_uart_tx #(.STOP_BITS(2)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(v[3]), .in_ready(rdy[3]), .in_data(d[3]),
                   .baud_div(div), .tx(tx_w[3]), .busy(busy_w[3]), .fifo_level(lvl[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask

  // Called at a negedge. Waits up to budget cycles for a start bit on the
  // selected instance, then samples every cycle of nb bits of div cycles.
  // f[i] = level of bit i; herr counts samples that moved inside a bit.
  task automatic rx_frame(input int nb, input int bdiv, input int budget,
                          output logic [15:0] f, output int herr, output int bcnt);
    int  w;
    logic bv;
    f = '0; herr = 0; bcnt = 0; w = 0; bv = 1'b0;
    while (tx_sel !== 1'b0 && w < budget) begin @(negedge clk); w++; end
    if (tx_sel !== 1'b0) begin herr = 999; return; end
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < bdiv; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (busy_sel === 1'b1) bcnt++;
        if (c == 0) begin bv = tx_sel; f[b] = bv; end
        else if (tx_sel !== bv) herr++;
      end
  endtask

  logic [15:0] f, fa [5];
  int          he, bc, hea [5], lows, bsy;
  logic [7:0]  words [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; v = '0; div = 16'd4; sel = 0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx",   tx_w[0], 1);
    chk("rst_rdy",  rdy[0], 1);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_lvl",  lvl[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xA5, default framing, divisor 4
    v[0] = 1'b1; d[0] = 8'hA5;
    @(negedge clk);
    v[0] = 1'b0;
    chk("a5_tx_e1",   tx_w[0], 1);
    chk("a5_lvl_e1",  lvl[0], 1);
    chk("a5_busy_e1", busy_w[0], 1);
    @(negedge clk);
    chk("a5_tx_e2",   tx_w[0], 0);
    chk("a5_lvl_e2",  lvl[0], 0);
    rx_frame(10, 4, 0, f, he, bc);
    chk("a5_frame", f, 16'h034A);
    chk("a5_hold",  he, 0);
    chk("a5_busy",  bc, 40);
    @(negedge clk);
    chk("a5_busy_end", busy_w[0], 0);
    chk("a5_tx_end",   tx_w[0], 1);

    // parity variants, 0x07 has three ones
    sel = 1; v[1] = 1'b1; d[1] = 8'h07;
    @(negedge clk); v[1] = 1'b0;
    rx_frame(11, 4, 10, f, he, bc);
    chk("even_frame", f, 16'h060E);
    chk("even_hold",  he, 0);
    @(negedge clk);
    chk("even_idle", tx_w[1], 1);
    sel = 2; v[2] = 1'b1; d[2] = 8'h07;
    @(negedge clk); v[2] = 1'b0;
    rx_frame(11, 4, 10, f, he, bc);
    chk("odd_frame", f, 16'h040E);
    chk("odd_hold",  he, 0);
    @(negedge clk);
    chk("odd_idle", tx_w[2], 1);

    // FIFO fill with in_valid held, five frames back to back
    sel = 0;
    fork
      begin
        v[0] = 1'b1; d[0] = words[0];
        for (int k = 0; k < 5; k++) begin
          chk("fill_rdy", rdy[0], 1);
          @(negedge clk);
          d[0] = words[k+1];
        end
        chk("full_rdy", rdy[0], 0);
        chk("full_lvl", lvl[0], 4);
        v[0] = 1'b0;
      end
      begin
        rx_frame(10, 4, 20, fa[0], hea[0], bc);
        for (int k = 1; k < 5; k++) begin
          @(negedge clk);
          rx_frame(10, 4, 0, fa[k], hea[k], bc);
        end
      end
    join
    for (int k = 0; k < 5; k++) begin
      chk("fill_frame", fa[k], {6'd0, 1'b1, words[k], 1'b0});
      chk("fill_hold",  hea[k], 0);
    end
    @(negedge clk);
    chk("fill_done", busy_w[0], 0);

    // two stop bits, second frame starts right after the second stop bit
    sel = 3; v[3] = 1'b1; d[3] = 8'h3C;
    @(negedge clk); d[3] = 8'hC3;
    @(negedge clk); v[3] = 1'b0;
    rx_frame(11, 4, 10, f, he, bc);
    chk("stop2_f0",   f, 16'h0678);
    chk("stop2_h0",   he, 0);
    @(negedge clk);
    rx_frame(11, 4, 0, f, he, bc);
    chk("stop2_f1",   f, 16'h0786);
    chk("stop2_h1",   he, 0);

    // divisor change mid-frame only affects the following frame
    sel = 0; v[0] = 1'b1; d[0] = 8'h5A;
    @(negedge clk); d[0] = 8'h96;
    @(negedge clk); v[0] = 1'b0;
    fork
      rx_frame(10, 4, 10, f, he, bc);
      begin repeat (10) @(negedge clk); div = 16'd8; end
    join
    chk("div_f0", f, 16'h02B4);
    chk("div_h0", he, 0);
    @(negedge clk);
    rx_frame(10, 8, 0, f, he, bc);
    chk("div_f1", f, 16'h032C);
    chk("div_h1", he, 0);
    repeat (3) @(negedge clk);

    // reset during a data bit with three words waiting
    div = 16'd4; v[0] = 1'b1; d[0] = 8'h01;
    for (int k = 0; k < 4; k++) begin @(negedge clk); d[0] = 8'h02 + 8'(k); end
    v[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_lvl",  lvl[0], 3);
    chk("mid_busy", busy_w[0], 1);
    rst_n = 1'b0; v[0] = 1'b1; d[0] = 8'hFF;
    @(negedge clk);
    chk("abort_tx",   tx_w[0], 1);
    chk("abort_busy", busy_w[0], 0);
    chk("abort_lvl",  lvl[0], 0);
    chk("abort_rdy",  rdy[0], 1);
    @(negedge clk);
    chk("rst_nopush", lvl[0], 0);
    v[0] = 1'b0; rst_n = 1'b1;
    lows = 0; bsy = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1) lows++;
      if (busy_w[0] !== 1'b0) bsy++;
    end
    chk("post_tx_lows", lows, 0);
    chk("post_busy",    bsy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
